// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared display-path definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W       : bits per decimal digit
//   state_t           : converter FSM encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   digits_for_width  : number of decimal digits needed to show any unsigned
//                       value of the given bit width (valid for width 1..63)
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counts decimal digits of the largest value representable in 'width'
    // bits, so a parent can check that DIGITS is large enough.
    function automatic int digits_for_width(input int width);
        longint unsigned maxVal;
        longint unsigned pow10;
        int              numDigits;
        maxVal    = (64'd1 << width) - 64'd1;
        pow10     = 64'd10;
        numDigits = 1;
        while (pow10 <= maxVal) begin
            numDigits = numDigits + 1;
            pow10     = pow10 * 64'd10;
        end
        return numDigits;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle between a binary source (master) and the converter
// (slave).
//   start   : master -> slave, conversion request
//   bin     : master -> slave, unsigned value to convert
//   busy    : slave -> master, conversion in progress or completing
//   done    : slave -> master, one-cycle result-valid pulse
//   bcd     : slave -> master, packed BCD digits, digit 0 least significant
//   nz_mask : slave -> master, leading-zero blanking mask
// -----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     nz_mask;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  nz_mask
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output nz_mask
    );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Per-digit double-dabble correction: digits of 5 or more get 3 added so
// that the following left shift carries correctly into the next digit.
//   i_digit : BCD digit before correction
//   o_digit : corrected digit (4-bit result, no carry out)
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Feeds the sevenseg decoders; bcd and nz_mask only change when a
// conversion completes, so the display never shows partial results.
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset, aborts any conversion
//   bus   : slave side of bin2bcd_seq_if (start/bin in, busy/done/bcd/nz_mask out)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clock,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);

    localparam int                ACC_W    = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DIGITS-1:0] NZ_RESET = DIGITS'(1);

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_shift;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_bcd;
    logic [DIGITS-1:0]   r_nzMask;

    logic                w_load;
    logic                w_step;
    logic                w_finish;
    logic [ACC_W-1:0]    w_adjusted;
    logic [ACC_W+WIDTH-1:0] w_combined;
    logic [ACC_W-1:0]    w_nextAcc;
    logic [WIDTH-1:0]    w_nextShift;
    logic [DIGITS-1:0]   w_nzMask;

    // Correct every accumulator digit from its pre-shift value.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One step of the algorithm: shift the corrected accumulator and the
    // remaining input bits left together. The accumulator MSB falls off,
    // which is harmless as long as DIGITS is large enough for WIDTH.
    assign w_combined  = {w_adjusted, r_shift} << 1;
    assign w_nextAcc   = w_combined[ACC_W+WIDTH-1 -: ACC_W];
    assign w_nextShift = w_combined[WIDTH-1:0];

    // Leading-zero mask of the step result, scanning from the most
    // significant digit down; the units digit is always shown.
    always_comb begin : nz_calc
        logic seen;
        seen     = 1'b0;
        w_nzMask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (|w_nextAcc[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
            w_nzMask[i] = seen;
        end
        w_nzMask[0] = 1'b1;
    end

    // Next-state logic. start only matters in IDLE; the last shift is the
    // one taken while the counter reads 1, and that edge publishes the result.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_ONE) begin
                    w_finish    = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Working registers advance while shifting; the visible result registers
    // are only written on the final shift so they hold the last conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_acc    <= '0;
            r_bcd    <= '0;
            r_nzMask <= NZ_RESET;
        end else begin
            if (w_load) begin
                r_shift <= bus.bin;
                r_acc   <= '0;
                r_cnt   <= CNT_INIT;
            end else if (w_step) begin
                r_shift <= w_nextShift;
                r_acc   <= w_nextAcc;
                r_cnt   <= r_cnt - CNT_ONE;
            end
            if (w_finish) begin
                r_bcd    <= w_nextAcc;
                r_nzMask <= w_nzMask;
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.bcd     = r_bcd;
    assign bus.nz_mask = r_nzMask;

endmodule
